// File: rtl/peripheral_ahb4_pkg.sv
// Shared AHB4 encodings plus the SRAM slave state type and address helpers.
package peripheral_ahb4_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Widest byte-lane vector any data width up to 1024 bits can need.
  localparam int AHB4_MAX_BE_W = 128;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    RD_WAIT,
    ERR1,
    ERR2
  } ahb4_sram_state_t;

  // Lanes [addr_lsb, addr_lsb + 2^hsize) set, clipped to the bus width.
  function automatic logic [AHB4_MAX_BE_W-1:0] ahb4_be(input logic [2:0] hsize,
                                                      input logic [6:0] addr_lsb,
                                                      input int         be_w);
    logic [AHB4_MAX_BE_W-1:0] be;
    int lo;
    int hi;
    be = '0;
    lo = int'(addr_lsb);
    hi = lo + (1 << hsize);
    for (int i = 0; i < AHB4_MAX_BE_W; i++) begin
      be[i] = (i >= lo) && (i < hi) && (i < be_w);
    end
    return be;
  endfunction

  // True when the byte offset is a multiple of the transfer size.
  function automatic logic ahb4_aligned(input logic [2:0] hsize,
                                        input logic [6:0] addr_lsb);
    logic [6:0] mask;
    mask = 7'((8'd1 << hsize) - 8'd1);
    return (addr_lsb & mask) == 7'd0;
  endfunction

endpackage

// File: rtl/peripheral_ahb4_sram_be_gen.sv
// Address-phase decode: legality check, byte lanes and SRAM word address.
module peripheral_ahb4_sram_be_gen
  import peripheral_ahb4_pkg::*;
#(
  parameter int HADDR_SIZE = 64,
  parameter int HDATA_SIZE = 64,
  parameter int MEM_DEPTH  = 256
) (
  input  logic [HADDR_SIZE-1:0]        haddr,
  input  logic [2:0]                   hsize,
  output logic                         illegal,
  output logic [HDATA_SIZE/8-1:0]      be,
  output logic [$clog2(MEM_DEPTH)-1:0] word_addr
);

  localparam int BE_W    = HDATA_SIZE / 8;
  localparam int BE_LOG2 = $clog2(BE_W);
  localparam int MEM_AW  = $clog2(MEM_DEPTH);
  localparam logic [2:0] MAX_SIZE = 3'(BE_LOG2);
  localparam logic [HADDR_SIZE-1:0] ADDR_LIMIT = HADDR_SIZE'(MEM_DEPTH * BE_W);

  logic [6:0]               addr_lsb;
  logic [AHB4_MAX_BE_W-1:0] be_wide;
  logic                     unused_be_bits;

  // Decode the live address phase; nothing here is registered.
  always_comb begin
    addr_lsb  = 7'(haddr[BE_LOG2-1:0]);
    be_wide   = ahb4_be(hsize, addr_lsb, BE_W);
    be        = be_wide[BE_W-1:0];
    word_addr = haddr[BE_LOG2 +: MEM_AW];
    illegal   = (hsize > MAX_SIZE) || !ahb4_aligned(hsize, addr_lsb) ||
                (haddr >= ADDR_LIMIT);
  end

  assign unused_be_bits = ^be_wide;

endmodule

// File: rtl/peripheral_ahb4_sram_slave.sv
// AHB-Lite slave terminating transfers into a 1-cycle-latency single-port SRAM.
// Handshake: an address phase is taken when HSEL, HREADY and an active HTRANS
// (NONSEQ/SEQ) coincide while this slave shows HREADYOUT=1; each data phase
// completes on the cycle HREADYOUT is high.
module peripheral_ahb4_sram_slave
  import peripheral_ahb4_pkg::*;
#(
  parameter int HADDR_SIZE = 64,
  parameter int HDATA_SIZE = 64,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                         HCLK,
  input  logic                         HRESET,
  input  logic                         HSEL,
  input  logic [HADDR_SIZE-1:0]        HADDR,
  input  logic [HDATA_SIZE-1:0]        HWDATA,
  input  logic                         HWRITE,
  input  logic [2:0]                   HSIZE,
  input  logic [2:0]                   HBURST,
  input  logic [3:0]                   HPROT,
  input  logic [1:0]                   HTRANS,
  input  logic                         HREADY,
  output logic                         HREADYOUT,
  output logic                         HRESP,
  output logic [HDATA_SIZE-1:0]        HRDATA,
  output logic                         mem_en,
  output logic                         mem_we,
  output logic [$clog2(MEM_DEPTH)-1:0] mem_addr,
  output logic [HDATA_SIZE/8-1:0]      mem_be,
  output logic [HDATA_SIZE-1:0]        mem_wdata,
  input  logic [HDATA_SIZE-1:0]        mem_rdata
);

  localparam int MEM_AW = $clog2(MEM_DEPTH);
  localparam int BE_W   = HDATA_SIZE / 8;

  ahb4_sram_state_t  state_q, state_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [BE_W-1:0]   be_q, be_d;

  logic              ap_illegal;
  logic [BE_W-1:0]   ap_be;
  logic [MEM_AW-1:0] ap_addr;
  logic              ap_sample;
  logic              ap_accept;
  logic              unused_inputs;

  // Burst type and protection carry no meaning for a flat SRAM.
  assign unused_inputs = ^{HBURST, HPROT};

  peripheral_ahb4_sram_be_gen #(
    .HADDR_SIZE(HADDR_SIZE),
    .HDATA_SIZE(HDATA_SIZE),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_be_gen (
    .haddr    (HADDR),
    .hsize    (HSIZE),
    .illegal  (ap_illegal),
    .be       (ap_be),
    .word_addr(ap_addr)
  );

  // Address phases are only taken in states that show HREADYOUT=1 and are not
  // finishing an error (ERR2 drops the pipelined address).
  always_comb begin
    ap_sample = (state_q == IDLE) || (state_q == READ) || (state_q == WRITE);
    ap_accept = ap_sample && !HRESET && HSEL && HREADY &&
                ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
  end

  // Next state and address/lane latch.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    be_d    = be_q;
    case (state_q)
      IDLE, READ, WRITE: begin
        state_d = IDLE;
        if (ap_accept) begin
          if (ap_illegal) begin
            state_d = ERR1;
          end else if (HWRITE) begin
            state_d = WRITE;
            addr_d  = ap_addr;
            be_d    = ap_be;
          end else if (state_q == WRITE) begin
            // SRAM port is busy committing the write: replay the read next cycle.
            state_d = RD_WAIT;
            addr_d  = ap_addr;
            be_d    = ap_be;
          end else begin
            state_d = READ;
          end
        end
      end
      RD_WAIT: state_d = READ;
      ERR1:    state_d = ERR2;
      ERR2:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus response follows the state; SRAM port muxes latch vs live address phase.
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    HRDATA    = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_be    = be_q;
    mem_wdata = '0;
    case (state_q)
      READ: HRDATA = mem_rdata;
      WRITE: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_wdata = HWDATA;
      end
      RD_WAIT: begin
        HREADYOUT = 1'b0;
        mem_en    = 1'b1;
      end
      ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
      end
      ERR2: HRESP = HRESP_ERROR;
      default: ;
    endcase
    // Zero-wait read: strobe the SRAM straight from the address phase.
    if (ap_accept && !ap_illegal && !HWRITE && (state_q != WRITE)) begin
      mem_en   = 1'b1;
      mem_we   = 1'b0;
      mem_addr = ap_addr;
      mem_be   = ap_be;
    end
  end

  // State and latch registers.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= IDLE;
      addr_q  <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
    end
  end

endmodule

// File: tb/tb_peripheral_ahb4_sram_slave.sv
// Bench for peripheral_ahb4_sram_slave: pipelined AHB driver, SRAM model,
// transaction-level reference model with a per-cycle compare, literal pins.
module tb_peripheral_ahb4_sram_slave;
  import peripheral_ahb4_pkg::*;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int DEPTH = 256;
  localparam int MAW = 8;
  localparam int BEW = 8;

  logic           HCLK = 1'b0;
  logic           HRESET, HSEL, HWRITE, HREADY, HREADYOUT, HRESP;
  logic [AW-1:0]  HADDR;
  logic [DW-1:0]  HWDATA, HRDATA;
  logic [2:0]     HSIZE, HBURST;
  logic [3:0]     HPROT;
  logic [1:0]     HTRANS;
  logic           mem_en, mem_we;
  logic [MAW-1:0] mem_addr;
  logic [BEW-1:0] mem_be;
  logic [DW-1:0]  mem_wdata;
  logic [DW-1:0]  mem_rdata = '0;
  logic           force_lo;

  // ---------------- clock / reset-related plumbing ----------------
  always #5 HCLK = ~HCLK;
  assign HREADY = force_lo ? 1'b0 : HREADYOUT;

  peripheral_ahb4_sram_slave #(.HADDR_SIZE(AW), .HDATA_SIZE(DW), .MEM_DEPTH(DEPTH)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS),
    .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // ---------------- SRAM model (environment) ----------------
  logic [DW-1:0]  sram [DEPTH];
  logic           req_en, req_we;
  logic [MAW-1:0] req_addr;
  logic [BEW-1:0] req_be;
  logic [DW-1:0]  req_wdata;

  always @(negedge HCLK) begin
    req_en = mem_en; req_we = mem_we; req_addr = mem_addr;
    req_be = mem_be; req_wdata = mem_wdata;
  end

  always @(posedge HCLK) begin
    if (req_en) begin
      if (req_we) begin
        for (int b = 0; b < BEW; b++)
          if (req_be[b]) sram[req_addr][8*b +: 8] <= req_wdata[8*b +: 8];
      end else begin
        mem_rdata <= sram[req_addr];
      end
    end
  end

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef enum int {DP_NONE, DP_WRITE, DP_READ, DP_ERR} dp_kind_t;
  logic [7:0]    ref_mem [2048];
  dp_kind_t      dp_kind = DP_NONE;
  logic [AW-1:0] dp_addr = '0;
  logic [2:0]    dp_size = '0;
  logic          dp_after_wr = 1'b0;
  int            dp_cyc = 0;
  logic          model_reset = 1'b0;

  // Observations for literal pins.
  int            mem_en_cnt, err_cnt, wait_cnt;
  logic [DW-1:0] last_rdata;
  logic [BEW-1:0] seen_be;
  logic [MAW-1:0] seen_addr;

  function automatic logic model_illegal(input logic [AW-1:0] a, input logic [2:0] s);
    return (s > 3'd3) || ((a % (64'd1 << s)) != 64'd0) || (a >= 64'd2048);
  endfunction

  function automatic logic [BEW-1:0] model_be(input logic [AW-1:0] a, input logic [2:0] s);
    logic [BEW-1:0] be;
    be = '0;
    for (int b = 0; b < (1 << s); b++) be[(int'(a[2:0]) + b) % 8] = 1'b1;
    return be;
  endfunction

  function automatic logic [DW-1:0] model_word(input logic [AW-1:0] a);
    logic [DW-1:0] w;
    int base;
    base = int'(a[10:0]) & ~7;
    for (int k = 0; k < 8; k++) w[8*k +: 8] = ref_mem[base + k];
    return w;
  endfunction

  task automatic model_commit(input logic [AW-1:0] a, input logic [2:0] s, input logic [DW-1:0] d);
    for (int b = 0; b < (1 << s); b++) begin
      int idx;
      idx = int'(a[10:0]) + b;
      ref_mem[idx] = d[8*(idx % 8) +: 8];
    end
  endtask

  // Compare DUT against the transaction model every cycle, then advance the model.
  always @(negedge HCLK) begin
    logic          exp_rdy, exp_resp, prev_wr;
    logic [DW-1:0] exp_rd;
    if (HRESET) begin
      dp_kind = DP_NONE;
    end else begin
      if (model_reset) begin
        dp_kind = DP_NONE;
        model_reset = 1'b0;
      end
      exp_rdy = 1'b1; exp_resp = 1'b0; exp_rd = '0;
      case (dp_kind)
        DP_ERR: begin exp_resp = 1'b1; exp_rdy = (dp_cyc != 0); end
        DP_READ: begin
          if (dp_after_wr && dp_cyc == 0) exp_rdy = 1'b0;
          else exp_rd = model_word(dp_addr);
        end
        default: ;
      endcase
      chk("hreadyout", 64'(HREADYOUT), 64'(exp_rdy));
      chk("hresp", 64'(HRESP), 64'(exp_resp));
      chk("hrdata", HRDATA, exp_rd);
      chk("mem_we", 64'(mem_we), 64'(dp_kind == DP_WRITE));
      if (dp_kind == DP_WRITE) begin
        chk("mem_addr", 64'(mem_addr), 64'(dp_addr[10:3]));
        chk("mem_be", 64'(mem_be), 64'(model_be(dp_addr, dp_size)));
        seen_be = mem_be; seen_addr = mem_addr;
      end
      if (mem_en) mem_en_cnt++;
      if (HRESP) err_cnt++;
      if (dp_kind == DP_READ) begin
        if (!HREADYOUT) wait_cnt++;
        else last_rdata = HRDATA;
      end
      if (HREADY) begin
        if (dp_kind == DP_WRITE) model_commit(dp_addr, dp_size, HWDATA);
        prev_wr = (dp_kind == DP_WRITE);
        if (dp_kind != DP_ERR && HSEL &&
            (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ)) begin
          dp_addr = HADDR; dp_size = HSIZE; dp_cyc = 0; dp_after_wr = 1'b0;
          if (model_illegal(HADDR, HSIZE)) dp_kind = DP_ERR;
          else if (HWRITE) dp_kind = DP_WRITE;
          else begin dp_kind = DP_READ; dp_after_wr = prev_wr; end
        end else begin
          dp_kind = DP_NONE;
        end
      end else begin
        dp_cyc++;
      end
    end
  end

  // ---------------- driver ----------------
  logic [DW-1:0] pend_wdata;

  // One address phase; HWDATA carries the previous transfer's data phase.
  task automatic addr_phase(input logic sel, input logic [1:0] trans, input logic wr,
                            input logic [AW-1:0] addr, input logic [2:0] size,
                            input logic [DW-1:0] wdata);
    logic rdy;
    int n;
    HSEL = sel; HTRANS = trans; HWRITE = wr; HADDR = addr; HSIZE = size;
    HWDATA = pend_wdata;
    n = 0;
    do begin
      @(negedge HCLK);
      rdy = HREADY;
      @(posedge HCLK);
      #1;
      n++;
    end while (!rdy && n < 20);
    chk("addr_phase_accepted", 64'(rdy), 64'd1);
    pend_wdata = wdata;
  endtask

  task automatic idle_phase();
    addr_phase(1'b0, HTRANS_IDLE, 1'b0, '0, 3'd0, '0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_hreadyout"}, 64'(HREADYOUT), 64'd1);
    chk({tag, "_hresp"}, 64'(HRESP), 64'd0);
    chk({tag, "_hrdata"}, HRDATA, 64'd0);
    chk({tag, "_mem_en"}, 64'(mem_en), 64'd0);
    chk({tag, "_mem_we"}, 64'(mem_we), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) sram[i] = '0;
    for (int i = 0; i < 2048; i++) ref_mem[i] = 8'h00;
    HRESET = 1'b1; HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0; HADDR = '0;
    HSIZE = 3'd0; HBURST = 3'b001; HPROT = 4'b0011; HWDATA = '0; force_lo = 1'b0;
    pend_wdata = '0; mem_en_cnt = 0; err_cnt = 0; wait_cnt = 0;
    last_rdata = '0; seen_be = '0; seen_addr = '0;
    repeat (2) @(posedge HCLK);
    #1;
    check_reset_outputs("reset");
    HRESET = 1'b0;

    // 1: DWORD write then read at 0x10, zero waits.
    seen_be = '0; seen_addr = '0;
    addr_phase(1'b1, HTRANS_NONSEQ, 1'b1, 64'h10, 3'd3, 64'h1122334455667788);
    idle_phase();
    chk("t1_mem_be", 64'(seen_be), 64'hFF);
    chk("t1_mem_addr", 64'(seen_addr), 64'd2);
    wait_cnt = 0; last_rdata = '0;
    addr_phase(1'b1, HTRANS_NONSEQ, 1'b0, 64'h10, 3'd3, '0);
    idle_phase();
    chk("t1_rdata", last_rdata, 64'h1122334455667788);
    chk("t1_waits", 64'(wait_cnt), 64'd0);

    // 2: byte write 0xAB at 0x13, read back the whole word.
    seen_be = '0;
    addr_phase(1'b1, HTRANS_NONSEQ, 1'b1, 64'h13, 3'd0, 64'h00000000AB000000);
    idle_phase();
    chk("t2_mem_be", 64'(seen_be), 64'h08);
    last_rdata = '0;
    addr_phase(1'b1, HTRANS_SEQ, 1'b0, 64'h10, 3'd3, '0);
    idle_phase();
    chk("t2_rdata", last_rdata, 64'h11223344AB667788);

    // 3: back-to-back write then read of the same word: one wait state.
    wait_cnt = 0; last_rdata = '0;
    addr_phase(1'b1, HTRANS_NONSEQ, 1'b1, 64'h20, 3'd3, 64'hDEADBEEFCAFEF00D);
    addr_phase(1'b1, HTRANS_NONSEQ, 1'b0, 64'h20, 3'd3, '0);
    idle_phase();
    chk("t3_waits", 64'(wait_cnt), 64'd1);
    chk("t3_rdata", last_rdata, 64'hDEADBEEFCAFEF00D);

    // 4: misaligned WORD and out-of-range DWORD both take the two-cycle ERROR.
    mem_en_cnt = 0; err_cnt = 0;
    addr_phase(1'b1, HTRANS_NONSEQ, 1'b0, 64'h22, 3'd2, '0);
    idle_phase();
    addr_phase(1'b1, HTRANS_NONSEQ, 1'b1, 64'h800, 3'd3, 64'hFFFFFFFFFFFFFFFF);
    idle_phase();
    chk("t4_mem_en_cycles", 64'(mem_en_cnt), 64'd0);
    chk("t4_error_cycles", 64'(err_cnt), 64'd4);

    // 5: IDLE, BUSY, unselected and HREADY-low address phases do nothing.
    mem_en_cnt = 0; err_cnt = 0;
    addr_phase(1'b1, HTRANS_IDLE, 1'b0, 64'h10, 3'd3, '0);
    addr_phase(1'b1, HTRANS_BUSY, 1'b0, 64'h10, 3'd3, '0);
    addr_phase(1'b0, HTRANS_NONSEQ, 1'b0, 64'h10, 3'd3, '0);
    force_lo = 1'b1; HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b0;
    HADDR = 64'h10; HSIZE = 3'd3;
    repeat (2) @(posedge HCLK);
    #1;
    force_lo = 1'b0; HSEL = 1'b0; HTRANS = HTRANS_IDLE;
    idle_phase();
    chk("t5_mem_en_cycles", 64'(mem_en_cnt), 64'd0);
    chk("t5_error_cycles", 64'(err_cnt), 64'd0);

    // 6: reset pulse in the read wait state, then data is still there.
    addr_phase(1'b1, HTRANS_NONSEQ, 1'b1, 64'h30, 3'd3, 64'h0123456789ABCDEF);
    HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b0; HADDR = 64'h10; HSIZE = 3'd3;
    HWDATA = pend_wdata;
    @(posedge HCLK);
    #1;
    HSEL = 1'b0; HTRANS = HTRANS_IDLE;
    chk("t6_in_wait_state", 64'(HREADYOUT), 64'd0);
    HRESET = 1'b1;
    #1;
    check_reset_outputs("t6_reset");
    HRESET = 1'b0;
    model_reset = 1'b1;
    @(posedge HCLK);
    #1;
    last_rdata = '0;
    addr_phase(1'b1, HTRANS_NONSEQ, 1'b0, 64'h10, 3'd3, '0);
    idle_phase();
    chk("t6_rdata", last_rdata, 64'h11223344AB667788);

    repeat (2) @(posedge HCLK);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
